// File: rtl/regfile_sb.sv
// regfile_sb
//   Multi-port register file with a per-register busy scoreboard.
//   Reads are combinational. A writeback in the same cycle is bypassed
//   to any reader of the same register, and it also clears that reader's
//   hazard flag. A destination register is reserved at issue and stays
//   busy until its writeback. A reservation of a register that is still
//   busy is refused (WAW stall) unless the older writeback lands in the
//   same cycle.
//
//   Optional build macro: REGFILE_SB_R0_ZERO_EN
//     When it is defined, register 0 is hardwired to zero. Writes to it
//     are dropped, reads of it return 0, and reservations of it are
//     accepted but never mark it busy.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   rd_addr    NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy    per-port hazard flag (register reserved, not yet written)
//   wr_en      writeback strobe
//   wr_addr    writeback register
//   wr_data    writeback value
//   rsv_valid  reservation request
//   rsv_addr   register to reserve
//   rsv_ready  reservation can be accepted this cycle
//   busy_vec   scoreboard, bit i = register i busy
//   busy_cnt   number of busy registers (registered)

module regfile_sb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_valid,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic                     rsv_ready,
   output logic [(2**ADDR_W)-1:0]   busy_vec,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic              wr_eff;
   logic              rsv_acc;
   logic              set_en;
   logic              inc;
   logic              dec;
   logic [CNT_W-1:0]  cnt_nxt;

   // wr_eff is the data write that really lands. set_en is an accepted
   // reservation that really marks a register busy.
`ifdef REGFILE_SB_R0_ZERO_EN
   assign wr_eff    = wr_en && (wr_addr != '0);
   assign rsv_ready = (rsv_addr == '0) || !busy[rsv_addr] ||
                      (wr_en && (wr_addr == rsv_addr));
   assign rsv_acc   = rsv_valid && rsv_ready;
   assign set_en    = rsv_acc && (rsv_addr != '0);
`else
   assign wr_eff    = wr_en;
   assign rsv_ready = !busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr));
   assign rsv_acc   = rsv_valid && rsv_ready;
   assign set_en    = rsv_acc;
`endif

   // When a writeback and a new reservation hit the same register, the
   // set is applied last, so the new reservation keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (wr_en)
         busy_nxt[wr_addr] = 1'b0;
      if (set_en)
         busy_nxt[rsv_addr] = 1'b1;
   end

   // The count is kept in step with busy_nxt instead of taking a popcount.
   // A same-address write plus re-reserve on a busy register is net 0.
   assign inc     = set_en && !busy[rsv_addr];
   assign dec     = wr_en && busy[wr_addr] && !(set_en && (rsv_addr == wr_addr));
   assign cnt_nxt = busy_cnt + CNT_W'(inc) - CNT_W'(dec);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (wr_eff)
            regs[wr_addr] <= wr_data;
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   assign busy_vec = busy;

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (wr_eff && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W]))
            rd_data[k*DATA_W +: DATA_W] = wr_data;
         else
            rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
         rd_busy[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]] &&
                      !(wr_en && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W]));
      end
   end

endmodule
